// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/FLUSH/HALT control of an external PC with branch decode.
// Optional return-address stack for CALL/RET is enabled by defining PC_RAS_EN.
module pc_sequencer #(
   parameter int unsigned RAS_DEPTH  = 4,
   parameter logic [9:0]  START_ADDR = 10'd0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       halt_req_i,
   input  logic [2:0] br_type_i,
   input  logic       br_cond_i,
   input  logic [7:0] rel_off_i,
   input  logic [9:0] abs_tgt_i,
   input  logic [9:0] p_ct_i,
   output logic       abs_jump_en_o,
   output logic [1:0] rel_jump_en_o,
   output logic [9:0] abs_jump_o,
   output logic [7:0] rel_jump_o,
   output logic       instr_valid_o,
   output logic       running_o,
   output logic       ras_err_o
);

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StHalt} state_e;

   localparam logic [2:0] BrRel    = 3'd1;
   localparam logic [2:0] BrFwd7   = 3'd2;
   localparam logic [2:0] BrBack14 = 3'd3;
   localparam logic [2:0] BrAbs    = 3'd4;
   localparam logic [2:0] BrCall   = 3'd5;
   localparam logic [2:0] BrRet    = 3'd6;

   localparam logic [1:0] RelInc    = 2'b00;
   localparam logic [1:0] RelOff    = 2'b01;
   localparam logic [1:0] RelFwd7   = 2'b10;
   localparam logic [1:0] RelBack14 = 2'b11;

   state_e state_q, state_d;

`ifdef PC_RAS_EN
   localparam int unsigned PtrW = $clog2(RAS_DEPTH + 1);

   logic [PtrW-1:0] ptr_q, ptr_d;
   logic [9:0]      ras_q [RAS_DEPTH];
   logic [9:0]      ras_d [RAS_DEPTH];
   logic            err_q, err_d;
   logic            push, pop, ras_clr, err_set;
   logic            ras_full, ras_empty;
   logic [9:0]      ras_top;

   assign ras_full  = (ptr_q == PtrW'(RAS_DEPTH));
   assign ras_empty = (ptr_q == '0);

   always_comb begin
      ras_top = '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
         if (PtrW'(i) == ptr_q - PtrW'(1)) ras_top = ras_q[i];
      end
   end

   // A full push is dropped so the oldest return addresses survive.
   always_comb begin
      ptr_d = ptr_q;
      ras_d = ras_q;
      err_d = err_q | err_set;
      if (ras_clr) begin
         ptr_d = '0;
      end else if (push) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            if (PtrW'(i) == ptr_q) ras_d[i] = p_ct_i + 10'd1;
         end
         ptr_d = ptr_q + PtrW'(1);
      end else if (pop) begin
         ptr_d = ptr_q - PtrW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         ptr_q <= ptr_d;
         err_q <= err_d;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
      end
   end

   assign ras_err_o = err_q;
`else
   logic unused_p_ct;
   assign unused_p_ct = ^p_ct_i;
   assign ras_err_o   = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      abs_jump_en_o = 1'b0;
      rel_jump_en_o = RelOff;
      abs_jump_o    = '0;
      rel_jump_o    = '0;
      instr_valid_o = 1'b0;
`ifdef PC_RAS_EN
      push    = 1'b0;
      pop     = 1'b0;
      ras_clr = 1'b0;
      err_set = 1'b0;
`endif
      unique case (state_q)
         StIdle, StHalt: begin
            if (start_i) begin
               abs_jump_en_o = 1'b1;
               abs_jump_o    = START_ADDR;
               state_d       = StRun;
`ifdef PC_RAS_EN
               ras_clr = 1'b1;
`endif
            end
         end
         StRun: begin
            instr_valid_o = 1'b1;
            rel_jump_en_o = RelInc;
            if (br_cond_i) begin
               case (br_type_i)
                  BrRel: begin
                     rel_jump_en_o = RelOff;
                     rel_jump_o    = rel_off_i;
                     state_d       = StFlush;
                  end
                  BrFwd7: begin
                     rel_jump_en_o = RelFwd7;
                     state_d       = StFlush;
                  end
                  BrBack14: begin
                     rel_jump_en_o = RelBack14;
                     state_d       = StFlush;
                  end
                  BrAbs, BrCall: begin
                     abs_jump_en_o = 1'b1;
                     abs_jump_o    = abs_tgt_i;
                     state_d       = StFlush;
`ifdef PC_RAS_EN
                     if (br_type_i == BrCall) begin
                        push    = !ras_full;
                        err_set = ras_full;
                     end
`endif
                  end
                  BrRet: begin
`ifdef PC_RAS_EN
                     if (ras_empty) begin
                        err_set = 1'b1;
                     end else begin
                        abs_jump_en_o = 1'b1;
                        abs_jump_o    = ras_top;
                        pop           = 1'b1;
                        state_d       = StFlush;
                     end
`endif
                  end
                  default: ;
               endcase
            end
            if (halt_req_i) state_d = StHalt;
         end
         StFlush: begin
            state_d = halt_req_i ? StHalt : StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   assign running_o = (state_q == StRun) || (state_q == StFlush);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RAS_DEPTH, default 4, number of return-address stack entries (2..8).
REQ-002 Parameter: START_ADDR, default 10'd0, address loaded into the PC on a start pulse.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 start  input  1  one-cycle pulse; leaves IDLE/HALT and begins execution at START_ADDR.
REQ-006 halt_req  input  1  level; stops sequencing at the next instruction boundary.
REQ-007 br_type  input  3  branch class of the current instruction: 0 NONE, 1 REL, 2 FWD7, 3 BACK14, 4 ABS, 5 CALL, 6 RET, 7 reserved (treated as NONE).
REQ-008 br_cond  input  1  condition met; a branch with br_cond=0 is not taken (NONE behaviour).
REQ-009 rel_off  input  8  signed relative offset for REL.
REQ-010 abs_tgt  input  10  absolute target for ABS and CALL.
REQ-011 p_ct  input  10  current PC value.
REQ-012 abs_jump_en  output  1  PC control: load abs_jump.
REQ-013 rel_jump_en  output  2  PC control: 00 +1, 01 +rel_jump, 10 +7, 11 -14.
REQ-014 abs_jump  output  10  absolute target to PC.
REQ-015 rel_jump  output  8  signed offset to PC.
REQ-016 instr_valid  output  1  instruction at p_ct is to be executed this cycle.
REQ-017 running  output  1  high in RUN and FLUSH.
REQ-018 ras_err  output  1  sticky: RAS overflow or underflow occurred.

Function
REQ-019 FSM states: IDLE, RUN, FLUSH, HALT.
REQ-020 IDLE/HALT: PC held (abs_jump_en=0, rel_jump_en=01, rel_jump=0); instr_valid=0.
REQ-021 IDLE/HALT + start: abs_jump_en=1, abs_jump=START_ADDR, next state RUN; RAS cleared.
REQ-022 RUN, taken branch: REL→01/rel_off; FWD7→10; BACK14→11; ABS→abs_jump_en=1, abs_tgt; next state FLUSH.
REQ-023 RUN, NONE or not taken: rel_jump_en=00 (PC+1); stay RUN.
REQ-024 FLUSH lasts exactly one cycle: instr_valid=0, PC+1 not issued (hold, rel 0), then RUN.
REQ-025 instr_valid=1 only in RUN; all br_* inputs ignored when instr_valid=0.
REQ-026 halt_req in RUN: current instruction completes (its PC control issued), next state HALT; in FLUSH: HALT after the flush cycle.
REQ-027 start and halt_req both high in IDLE/HALT: start wins, halt takes effect after the first RUN cycle.
REQ-028 Offset arithmetic is the PC's 10-bit modular wrap; sequencer performs no range checks.
REQ-029 Output controls are combinational from state and inputs; one-cycle latency from branch decode to new p_ct.

Reset
REQ-030 reset=0 asynchronously forces: state IDLE, RAS pointer 0, ras_err=0, abs_jump_en=0, rel_jump_en=01, rel_jump=0, abs_jump=0, instr_valid=0, running=0.
REQ-031 Reset mid-RUN/FLUSH discards in-flight branch; after release, stays IDLE until start.

Configuration
REQ-032 Macro PC_RAS_EN: when defined, CALL pushes p_ct+1 and jumps to abs_tgt; RET pops and jumps abs to popped value; both enter FLUSH.
REQ-033 PC_RAS_EN push when full: oldest entry not overwritten, jump still taken, ras_err set; pop when empty: PC+1, no FLUSH, ras_err set.
REQ-034 Without PC_RAS_EN: no stack storage; CALL behaves as ABS, RET as NONE; ras_err tied 0.

Verification
REQ-035 reset release, start pulse, 3 NONE instructions → p_ct 0,1,2,3; instr_valid 1 in RUN only.
REQ-036 At p_ct=20: BACK14 taken → p_ct 6, one FLUSH cycle instr_valid=0, p_ct held at 6, then RUN.
REQ-037 REL rel_off=-3 with br_cond=0 at p_ct=10 → p_ct 11, no FLUSH.
REQ-038 PC_RAS_EN: CALL abs_tgt=100 at p_ct=5, RET at 100 → p_ct 100 then 6; ras_err=0.
REQ-039 PC_RAS_EN, RAS_DEPTH=4: 5 nested CALLs → ras_err=1 after 5th; RET with empty stack → PC+1, ras_err stays 1.
REQ-040 halt_req during FLUSH then reset=0 mid-HALT → IDLE, all outputs at reset values, start restarts at START_ADDR.
